// File: rtl/fpnew_opgroup_out_buffer.sv
// Output buffer for an FPU operation group: an in-order FIFO of results with
// their status flags, extension bit and tag. It also accumulates sticky
// exception flags from every entry the writeback side consumes.
module fpnew_opgroup_out_buffer #(
    parameter int unsigned Width   = 32,
    parameter int unsigned TagType = 1,
    // Number of buffered entries, 1..16; need not be a power of two.
    parameter int unsigned Depth   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    // Upstream (opgroup) side
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           result_i,
    input  logic [4:0]                 status_i,
    input  logic                       extension_bit_i,
    input  logic [TagType:0]           tag_i,
    // Downstream (writeback) side
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic                       extension_bit_o,
    output logic [TagType:0]           tag_o,
    // Occupancy and accumulated flags
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic                       busy_o
);

    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned UsageW = $clog2(Depth + 1);

    typedef struct packed {
        logic [Width-1:0] result;
        logic [4:0]       status;
        logic             ext_bit;
        logic [TagType:0] tag;
    } entry_t;

    entry_t            mem [Depth];
    entry_t            in_entry;
    entry_t            head;

    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [UsageW-1:0] usage_q, usage_d;
    logic [4:0]        fflags_q, fflags_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Pointers wrap explicitly at Depth-1 so non power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    // Handshake qualification; both sides derive only from registered occupancy.
    always_comb begin
        full  = (usage_q == UsageW'(Depth));
        empty = (usage_q == '0);
        push  = in_valid_i & ~full & ~flush_i;
        pop   = ~empty & out_ready_i & ~flush_i;
    end

    // Pack the incoming fields into one storage word.
    always_comb begin
        in_entry         = '0;
        in_entry.result  = result_i;
        in_entry.status  = status_i;
        in_entry.ext_bit = extension_bit_i;
        in_entry.tag     = tag_i;
    end

    // Next-state for pointers and occupancy; flush overrides any handshake.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        usage_d  = usage_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            usage_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   usage_d = usage_q + UsageW'(1);
                2'b01:   usage_d = usage_q - UsageW'(1);
                default: usage_d = usage_q;
            endcase
        end
    end

    // Sticky flags: a clear in the same cycle as a pop keeps only the popped status.
    always_comb begin
        fflags_d = fflags_q;
        if (pop) begin
            fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | head.status;
        end else if (fflags_clr_i) begin
            fflags_d = 5'b0;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
            fflags_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            usage_q  <= usage_d;
            fflags_q <= fflags_d;
        end
    end

    // Entry storage; contents are never visible while empty, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= in_entry;
        end
    end

    // Head entry is forced to zero while empty so stale data never leaks out.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr_q];
        end
    end

    // Output drive.
    always_comb begin
        in_ready_o      = ~full;
        out_valid_o     = ~empty;
        busy_o          = ~empty;
        usage_o         = usage_q;
        fflags_o        = fflags_q;
        result_o        = head.result;
        status_o        = head.status;
        extension_bit_o = head.ext_bit;
        tag_o           = head.tag;
    end

endmodule
